ulaplus_palette_loader: RTL and testbench

- Bus initiator that programs the ULAplus palette and config register without CPU involvement.
- Requests the Z80 bus with BUSRQ and streams NENTRIES palette bytes from a synchronous source memory (boot ROM/BRAM) through the ULAplus ports. Each entry is a write to 0xBF3B (register select) followed by a write to 0xFF3B (data).
- Finishes with a config write and releases the bus.
- Sits beside the CPU on the shared I/O bus feeding the ULA's port decoders. Used for boot-time palettes and menu-driven palette swaps.

---
 rtl/ulaplus_palette_loader.sv | 192 +++++++++++++++++++
 tb/tb_ulaplus_palette_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulaplus_palette_loader.sv
// ULAplus palette loader: takes the Z80 bus and streams palette entries
// plus the config byte through the ULAplus select/data ports.
module ulaplus_palette_loader #(
    parameter int         NENTRIES  = 64,
    parameter int         STROBE    = 2,
    parameter logic [7:0] CFG_VALUE = 8'h01,
    parameter bit         WRITE_CFG = 1'b1
) (
    input  logic        clk7,
    input  logic        rst_n,
    input  logic        start,
    output logic        busrq_n,
    input  logic        busak_n,
    output logic        bus_oe,
    output logic [15:0] a,
    output logic [7:0]  dout,
    output logic        iorq_n,
    output logic        wr_n,
    output logic        mreq_n,
    output logic        rd_n,
    output logic [5:0]  src_addr,
    input  logic [7:0]  src_data,
    output logic        busy,
    output logic        done
);

    localparam int SW = (STROBE > 1) ? $clog2(STROBE) : 1;
    localparam logic [SW-1:0] STB_LAST = SW'(STROBE - 1);
    localparam logic [5:0] CNT_LAST = 6'(NENTRIES - 1);
    localparam logic [15:0] A_SEL = 16'hBF3B;
    localparam logic [15:0] A_DAT = 16'hFF3B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SETUP,
        S_STB,
        S_HOLD,
        S_REL
    } state_t;

    state_t        state, state_nx;
    logic          data_ph, data_ph_nx;
    logic          cfg_ph, cfg_ph_nx;
    logic [5:0]    cnt, cnt_nx;
    logic [SW-1:0] stb_cnt, stb_cnt_nx;
    logic [1:0]    ak_sync;
    logic          ak_n;
    logic [7:0]    cap;

    logic          busrq_nx, oe_nx, stb_nx, busy_nx, done_nx;
    logic [15:0]   a_nx;
    logic [7:0]    dout_nx;
    logic [5:0]    src_addr_nx;

    assign ak_n   = ak_sync[1];
    assign mreq_n = 1'b1;
    assign rd_n   = 1'b1;

    always_ff @(posedge clk7 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            data_ph <= 1'b0;
            cfg_ph  <= 1'b0;
            cnt     <= '0;
            stb_cnt <= '0;
            ak_sync <= 2'b11;
            cap     <= '0;
        end else begin
            state   <= state_nx;
            data_ph <= data_ph_nx;
            cfg_ph  <= cfg_ph_nx;
            cnt     <= cnt_nx;
            stb_cnt <= stb_cnt_nx;
            ak_sync <= {ak_sync[0], busak_n};
            // source byte is valid one cycle after ASETUP drove src_addr
            if (state == S_STB && !data_ph && !cfg_ph && stb_cnt == '0)
                cap <= src_data;
        end
    end

    always_comb begin
        state_nx   = state;
        data_ph_nx = data_ph;
        cfg_ph_nx  = cfg_ph;
        cnt_nx     = cnt;
        stb_cnt_nx = stb_cnt;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx   = S_REQ;
                    data_ph_nx = 1'b0;
                    cfg_ph_nx  = 1'b0;
                    cnt_nx     = '0;
                end
            end
            S_REQ: begin
                if (!ak_n)
                    state_nx = S_SETUP;
            end
            S_SETUP: begin
                stb_cnt_nx = '0;
                state_nx   = ak_n ? S_REL : S_STB;
            end
            S_STB: begin
                if (ak_n)
                    state_nx = S_REL;
                else if (stb_cnt == STB_LAST)
                    state_nx = S_HOLD;
                else
                    stb_cnt_nx = stb_cnt + 1'b1;
            end
            S_HOLD: begin
                if (ak_n) begin
                    state_nx = S_REL;
                end else if (!data_ph) begin
                    state_nx   = S_SETUP;
                    data_ph_nx = 1'b1;
                end else if (cfg_ph) begin
                    state_nx = S_REL;
                end else if (cnt == CNT_LAST) begin
                    if (WRITE_CFG) begin
                        state_nx   = S_SETUP;
                        cfg_ph_nx  = 1'b1;
                        data_ph_nx = 1'b0;
                    end else begin
                        state_nx = S_REL;
                    end
                end else begin
                    state_nx   = S_SETUP;
                    data_ph_nx = 1'b0;
                    cnt_nx     = cnt + 6'd1;
                end
            end
            S_REL: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // bus outputs are computed from the next state and registered
    always_comb begin
        oe_nx       = (state_nx == S_SETUP) || (state_nx == S_STB)
                    || (state_nx == S_HOLD);
        busrq_nx    = !(oe_nx || state_nx == S_REQ);
        stb_nx      = (state_nx == S_STB);
        busy_nx     = (state_nx != S_IDLE);
        done_nx     = (state == S_REL);
        a_nx        = 16'h0000;
        dout_nx     = 8'hFF;
        src_addr_nx = src_addr;
        if (oe_nx) begin
            a_nx = data_ph_nx ? A_DAT : A_SEL;
            unique case (1'b1)
                (!data_ph_nx && cfg_ph_nx):  dout_nx = 8'h40;
                (!data_ph_nx && !cfg_ph_nx): dout_nx = {2'b00, cnt_nx};
                (data_ph_nx && cfg_ph_nx):   dout_nx = CFG_VALUE;
                default:                     dout_nx = cap;
            endcase
        end
        if (state_nx == S_SETUP && !data_ph_nx && !cfg_ph_nx)
            src_addr_nx = cnt_nx;
    end

    always_ff @(posedge clk7 or negedge rst_n) begin
        if (!rst_n) begin
            busrq_n  <= 1'b1;
            bus_oe   <= 1'b0;
            iorq_n   <= 1'b1;
            wr_n     <= 1'b1;
            a        <= 16'h0000;
            dout     <= 8'hFF;
            src_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busrq_n  <= busrq_nx;
            bus_oe   <= oe_nx;
            iorq_n   <= !stb_nx;
            wr_n     <= !stb_nx;
            a        <= a_nx;
            dout     <= dout_nx;
            src_addr <= src_addr_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

endmodule

// File: tb/tb_ulaplus_palette_loader.sv
// Bench for ulaplus_palette_loader: bus monitors compare every I/O write
// against a queue of expected (address, data) pairs.
module tb_ulaplus_palette_loader;

    logic clk7 = 1'b0;
    always #5 clk7 = ~clk7;

    logic        rst_n, start, busak_n;
    logic        busrq_n, bus_oe, iorq_n, wr_n, mreq_n, rd_n, busy, done;
    logic [15:0] a;
    logic [7:0]  dout, src_data;
    logic [5:0]  src_addr;

    logic        start2;
    logic        busak2_n = 1'b1;
    logic        busrq2_n, bus_oe2, iorq2_n, wr2_n, mreq2_n, rd2_n;
    logic        busy2, done2;
    logic [15:0] a2;
    logic [7:0]  dout2, src2_data;
    logic [5:0]  src2_addr;

    ulaplus_palette_loader u_dut (
        .clk7(clk7), .rst_n(rst_n), .start(start),
        .busrq_n(busrq_n), .busak_n(busak_n), .bus_oe(bus_oe),
        .a(a), .dout(dout), .iorq_n(iorq_n), .wr_n(wr_n),
        .mreq_n(mreq_n), .rd_n(rd_n), .src_addr(src_addr),
        .src_data(src_data), .busy(busy), .done(done)
    );

    ulaplus_palette_loader #(
        .NENTRIES(4), .STROBE(3), .CFG_VALUE(8'h01), .WRITE_CFG(1'b0)
    ) u_dut2 (
        .clk7(clk7), .rst_n(rst_n), .start(start2),
        .busrq_n(busrq2_n), .busak_n(busak2_n), .bus_oe(bus_oe2),
        .a(a2), .dout(dout2), .iorq_n(iorq2_n), .wr_n(wr2_n),
        .mreq_n(mreq2_n), .rd_n(rd2_n), .src_addr(src2_addr),
        .src_data(src2_data), .busy(busy2), .done(done2)
    );

    // synchronous source memories holding addr ^ A5
    always_ff @(posedge clk7) begin
        src_data  <= {2'b00, src_addr} ^ 8'hA5;
        src2_data <= {2'b00, src2_addr} ^ 8'hA5;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    logic [23:0] q1[$];
    logic [23:0] q2[$];
    int wr1 = 0, wr2 = 0, lo1 = 0, lo2 = 0, dn2 = 0, cyc = 0, last2 = -1;
    logic pi1 = 1'b1, pi2 = 1'b1;

    // bus monitors, sampled just after each rising edge
    always begin
        @(posedge clk7);
        #1;
        cyc++;
        if (!rst_n) begin
            pi1 = 1'b1; lo1 = 0; pi2 = 1'b1; lo2 = 0; last2 = -1;
        end else begin
            if (!iorq_n) begin
                if (pi1) begin
                    wr1++;
                    if (q1.size() == 0) check("mon1_extra", q1.size(), 1);
                    else check("mon1_wr", {8'h00, a, dout}, {8'h00, q1.pop_front()});
                    check("mon1_ctl", {wr_n, mreq_n, rd_n, bus_oe}, 4'b0111);
                end
                lo1++;
            end else if (!pi1) begin
                check("mon1_low", lo1, 2);
                lo1 = 0;
            end
            pi1 = iorq_n;

            if (!bus_oe2) last2 = -1;
            if (!iorq2_n) begin
                if (pi2) begin
                    wr2++;
                    if (q2.size() == 0) check("mon2_extra", q2.size(), 1);
                    else check("mon2_wr", {8'h00, a2, dout2}, {8'h00, q2.pop_front()});
                    if (last2 >= 0) check("mon2_gap", cyc - last2, 5);
                    last2 = cyc;
                end
                lo2++;
            end else if (!pi2) begin
                check("mon2_low", lo2, 3);
                lo2 = 0;
            end
            pi2 = iorq2_n;
            if (done2) dn2++;
        end
    end

    // simple grant responder for the short-upload instance
    int g2 = 0;
    always @(negedge clk7) begin
        if (busrq2_n) begin
            g2 = 0;
            busak2_n = 1'b1;
        end else if (g2 < 3) begin
            g2++;
        end else begin
            busak2_n = 1'b0;
        end
    end

    task automatic push_full();
        for (int i = 0; i < 64; i++) begin
            q1.push_back({16'hBF3B, 2'b00, 6'(i)});
            q1.push_back({16'hFF3B, 8'(i) ^ 8'hA5});
        end
        q1.push_back({16'hBF3B, 8'h40});
        q1.push_back({16'hFF3B, 8'h01});
    endtask

    task automatic push_short();
        for (int i = 0; i < 4; i++) begin
            q2.push_back({16'hBF3B, 2'b00, 6'(i)});
            q2.push_back({16'hFF3B, 8'(i) ^ 8'hA5});
        end
    endtask

    task automatic start1();
        @(negedge clk7);
        start = 1'b1;
        @(negedge clk7);
        start = 1'b0;
        check("start_busy", {busy, busrq_n}, 2'b10);
    endtask

    // grant three cycles after the request; bus_oe must follow the
    // first sampling edge by the two synchroniser stages
    task automatic grant1();
        int lat;
        repeat (3) @(negedge clk7);
        busak_n = 1'b0;
        @(posedge clk7);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk7);
            #1;
            lat++;
            if (bus_oe) break;
        end
        check("grant_lat", lat, 2);
    endtask

    task automatic wait_wr1(input int n);
        for (int i = 0; i < 2000 && wr1 < n; i++) @(negedge clk7);
        check("wait_wr1", wr1 >= n, 1);
    endtask

    task automatic finish1();
        int n;
        n = 1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk7);
            #1;
            if (!bus_oe) break;
            n++;
        end
        check("oe_cycles", n, 520);
        check("rel_bus", {busrq_n, iorq_n, a, dout}, {2'b11, 16'h0000, 8'hFF});
        @(posedge clk7);
        #1;
        check("done_hi", {done, busy}, 2'b10);
        @(posedge clk7);
        #1;
        check("done_lo", done, 0);
        busak_n = 1'b1;
    endtask

    initial begin
        int wb, lat, wc;
        rst_n = 1'b0; start = 1'b0; busak_n = 1'b1; start2 = 1'b0;
        repeat (3) @(negedge clk7);
        check("rst_ctl", {busrq_n, bus_oe, iorq_n, wr_n, mreq_n, rd_n, busy, done},
              8'b10111100);
        check("rst_a", a, 16'h0000);
        check("rst_dout", dout, 8'hFF);
        check("rst_src", src_addr, 0);
        rst_n = 1'b1;

        // full default upload
        push_full();
        wb = wr1;
        start1();
        grant1();
        finish1();
        check("full_wr", wr1 - wb, 130);
        check("full_q", q1.size(), 0);

        // reset during the select strobe of entry 10
        repeat (4) @(negedge clk7);
        push_full();
        wb = wr1;
        start1();
        grant1();
        wait_wr1(wb + 21);
        check("mid_stb", {iorq_n, a}, {1'b0, 16'hBF3B});
        #2 rst_n = 1'b0;
        #1;
        check("arst_ctl", {busrq_n, bus_oe, iorq_n, wr_n, busy, done}, 6'b101100);
        check("arst_bus", {a, dout, 2'b00, src_addr}, {16'h0000, 8'hFF, 8'h00});
        repeat (2) @(negedge clk7);
        q1.delete();
        busak_n = 1'b1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk7);
        push_full();
        wb = wr1;
        start1();
        grant1();
        finish1();
        check("rerun_wr", wr1 - wb, 130);
        check("rerun_q", q1.size(), 0);

        // grant withdrawn at entry 20
        repeat (4) @(negedge clk7);
        push_full();
        wb = wr1;
        start1();
        grant1();
        wait_wr1(wb + 41);
        busak_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk7);
            #1;
            lat++;
            if (!bus_oe) break;
        end
        check("abort_lat", lat <= 3, 1);
        check("abort_bus", {busrq_n, iorq_n, wr_n, a}, {3'b111, 16'h0000});
        for (int i = 0; i < 5 && !done; i++) begin
            @(posedge clk7);
            #1;
        end
        check("abort_done", {done, busy}, 2'b10);
        wc = wr1;
        @(posedge clk7);
        #1;
        check("abort_pulse", done, 0);
        repeat (20) @(negedge clk7);
        check("abort_nowr", wr1, wc);
        q1.delete();

        // short instance: starts while busy are ignored
        push_short();
        wb = wr2;
        @(negedge clk7);
        start2 = 1'b1;
        @(negedge clk7);
        start2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat (7) @(negedge clk7);
            check("ign_busy", busy2, 1);
            start2 = 1'b1;
            @(negedge clk7);
            start2 = 1'b0;
        end
        push_short();
        for (int i = 0; i < 200 && !done2; i++) @(negedge clk7);
        check("s1_done", done2, 1);
        check("s1_wr", wr2 - wb, 8);
        // start in the same cycle as done
        start2 = 1'b1;
        @(negedge clk7);
        start2 = 1'b0;
        check("s2_busy", {busy2, done2}, 2'b10);
        for (int i = 0; i < 200 && !done2; i++) @(negedge clk7);
        check("s2_done", done2, 1);
        repeat (3) @(negedge clk7);
        check("s2_wr", wr2 - wb, 16);
        check("s2_q", q2.size(), 0);
        check("s2_pulses", dn2, 2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
